jtframe_uart_bridge: RTL and testbench

//  Byte-level command parser that sits downstream of jtframe_uart (rx side) and upstream of it (tx side).

---
 rtl/jtframe_uart_bridge_pkg.sv | 25 ++
 rtl/jtframe_uart_bridge.sv | 193 +++++++++++++++++++
 tb/tb_jtframe_uart_bridge.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtframe_uart_bridge_pkg.sv
// Shared opcode and reply byte values plus the parser state encoding.
// Host-side tools and the testbench use the same values, so the wire protocol is defined in one place.
// No logic lives here. The package holds only constants and types.
package jtframe_uart_bridge_pkg;

    // Frame opcodes sent by the host
    localparam logic [7:0] OP_RD   = 8'h52;  // 'R' AH AL
    localparam logic [7:0] OP_WR   = 8'h57;  // 'W' AH AL D

    // Reply bytes returned to the host
    localparam logic [7:0] RPL_OK  = 8'h4B;  // 'K' write done
    localparam logic [7:0] RPL_BAD = 8'h3F;  // '?' unknown opcode
    localparam logic [7:0] RPL_ERR = 8'h21;  // '!' framing error or bus timeout

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_H  = 3'd1,
        ST_ADDR_L  = 3'd2,
        ST_DATA    = 3'd3,
        ST_BUS     = 3'd4,
        ST_TX      = 3'd5,
        ST_TX_WAIT = 3'd6
    } state_t;

endpackage

// File: rtl/jtframe_uart_bridge.sv
// Purpose: decodes host frames 'R' AH AL and 'W' AH AL D into single-byte debug-bus accesses, with one reply byte per frame.
// Latency: a zero-wait read raises tx_wr_o 3 cycles after the AL byte is accepted.
// Backpressure: rx bytes stay pending outside the parse states; the bus request is held until bus_ok_i or BUS_TO; tx waits for !tx_busy_i.
// Ports: clk_i/rst_n_i; rx_data_i/rx_rdy_i/rx_error_i/rx_clr_o (UART rx side);
//        tx_data_o/tx_wr_o/tx_busy_i (UART tx side); bus_addr_o/bus_dout_o/bus_we_o/bus_rd_o/bus_din_i/bus_ok_i (debug bus).
module jtframe_uart_bridge
    import jtframe_uart_bridge_pkg::*;
#(
    parameter int AW      = 16,
    parameter int TIMEOUT = 5000000,
    parameter int BUS_TO  = 255
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_rdy_i,
    input  logic          rx_error_i,
    output logic          rx_clr_o,
    output logic [7:0]    tx_data_o,
    output logic          tx_wr_o,
    input  logic          tx_busy_i,
    output logic [AW-1:0] bus_addr_o,
    output logic [7:0]    bus_dout_o,
    output logic          bus_we_o,
    output logic          bus_rd_o,
    input  logic [7:0]    bus_din_i,
    input  logic          bus_ok_i
);

    localparam logic [23:0] TO_LAST  = 24'(TIMEOUT - 1);
    localparam logic [7:0]  BUS_LAST = 8'(BUS_TO - 1);

    state_t        state_q, state_d;
    logic          is_wr_q, is_wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    dout_q, dout_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          rx_clr_q, rx_clr_d;
    logic          tx_wr_q, tx_wr_d;
    logic          bus_we_q, bus_we_d;
    logic          bus_rd_q, bus_rd_d;
    logic [23:0]   to_cnt_q, to_cnt_d;
    logic [7:0]    bus_cnt_q, bus_cnt_d;
    logic          wait_first_q, wait_first_d;

    logic parse_st;
    logic accept;

    // rx_rdy_i is still high in the cycle rx_clr_o is asserted, so gating on rx_clr_q prevents double consumption.
    assign parse_st = (state_q == ST_IDLE) || (state_q == ST_ADDR_H) ||
                      (state_q == ST_ADDR_L) || (state_q == ST_DATA);
    assign accept   = parse_st && rx_rdy_i && !rx_clr_q;

    always_comb begin
        state_d      = state_q;
        is_wr_d      = is_wr_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        tx_data_d    = tx_data_q;
        rx_clr_d     = 1'b0;
        tx_wr_d      = 1'b0;
        bus_we_d     = bus_we_q;
        bus_rd_d     = bus_rd_q;
        to_cnt_d     = to_cnt_q;
        bus_cnt_d    = bus_cnt_q;
        wait_first_d = wait_first_q;

        if (accept) begin
            rx_clr_d = 1'b1;
            to_cnt_d = '0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (rx_error_i) begin
                        tx_data_d = RPL_ERR;
                        state_d   = ST_TX;
                    end else if (rx_data_i == OP_RD || rx_data_i == OP_WR) begin
                        is_wr_d = (rx_data_i == OP_WR);
                        state_d = ST_ADDR_H;
                    end else begin
                        tx_data_d = RPL_BAD;
                        state_d   = ST_TX;
                    end
                end
            end
            ST_ADDR_H, ST_ADDR_L, ST_DATA: begin
                if (accept) begin
                    if (rx_error_i) begin
                        tx_data_d = RPL_ERR;
                        state_d   = ST_TX;
                    end else if (state_q == ST_ADDR_H) begin
                        // Holds AH until AL arrives; AH bits above AW are dropped.
                        addr_d  = AW'({8'h00, rx_data_i});
                        state_d = ST_ADDR_L;
                    end else if (state_q == ST_ADDR_L) begin
                        // {AH, AL} truncated to AW bits.
                        addr_d = AW'({addr_q, rx_data_i});
                        if (is_wr_q) begin
                            state_d = ST_DATA;
                        end else begin
                            bus_rd_d  = 1'b1;
                            bus_cnt_d = '0;
                            state_d   = ST_BUS;
                        end
                    end else begin
                        dout_d    = rx_data_i;
                        bus_we_d  = 1'b1;
                        bus_cnt_d = '0;
                        state_d   = ST_BUS;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    // Silent abandon: a partial frame gets no reply.
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 24'd1;
                end
            end
            ST_BUS: begin
                // bus_ok_i is checked first, so an acknowledge in the last allowed cycle wins.
                if (bus_ok_i) begin
                    bus_rd_d  = 1'b0;
                    bus_we_d  = 1'b0;
                    tx_data_d = is_wr_q ? RPL_OK : bus_din_i;
                    state_d   = ST_TX;
                end else if (bus_cnt_q == BUS_LAST) begin
                    bus_rd_d  = 1'b0;
                    bus_we_d  = 1'b0;
                    tx_data_d = RPL_ERR;
                    state_d   = ST_TX;
                end else begin
                    bus_cnt_d = bus_cnt_q + 8'd1;
                end
            end
            ST_TX: begin
                if (!tx_busy_i) begin
                    tx_wr_d      = 1'b1;
                    wait_first_d = 1'b1;
                    state_d      = ST_TX_WAIT;
                end
            end
            ST_TX_WAIT: begin
                // The UART raises busy one cycle after tx_wr, so the first cycle carries no information.
                if (wait_first_q) begin
                    wait_first_d = 1'b0;
                end else if (!tx_busy_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            is_wr_q      <= 1'b0;
            addr_q       <= '0;
            dout_q       <= '0;
            tx_data_q    <= '0;
            rx_clr_q     <= 1'b0;
            tx_wr_q      <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_rd_q     <= 1'b0;
            to_cnt_q     <= '0;
            bus_cnt_q    <= '0;
            wait_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_wr_q      <= is_wr_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            tx_data_q    <= tx_data_d;
            rx_clr_q     <= rx_clr_d;
            tx_wr_q      <= tx_wr_d;
            bus_we_q     <= bus_we_d;
            bus_rd_q     <= bus_rd_d;
            to_cnt_q     <= to_cnt_d;
            bus_cnt_q    <= bus_cnt_d;
            wait_first_q <= wait_first_d;
        end
    end

    assign rx_clr_o   = rx_clr_q;
    assign tx_data_o  = tx_data_q;
    assign tx_wr_o    = tx_wr_q;
    assign bus_addr_o = addr_q;
    assign bus_dout_o = dout_q;
    assign bus_we_o   = bus_we_q;
    assign bus_rd_o   = bus_rd_q;

endmodule

// File: tb/tb_jtframe_uart_bridge.sv
// Bench for jtframe_uart_bridge: host byte source, 256-byte RAM with programmable ack delay, UART tx busy model.
// Expected replies and bus accesses are derived per frame from the protocol rules into queues.
// A negedge monitor compares every bus request and every tx strobe against those queues.
module tb_jtframe_uart_bridge;
    import jtframe_uart_bridge_pkg::*;

    localparam int AW      = 12;
    localparam int TIMEOUT = 300;
    localparam int BUS_TO  = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    rx_data;
    logic          rx_rdy;
    logic          rx_error;
    logic          rx_clr;
    logic [7:0]    tx_data;
    logic          tx_wr;
    logic          tx_busy;
    logic [AW-1:0] bus_addr;
    logic [7:0]    bus_dout;
    logic          bus_we;
    logic          bus_rd;
    logic [7:0]    bus_din;
    logic          bus_ok;

    jtframe_uart_bridge #(.AW(AW), .TIMEOUT(TIMEOUT), .BUS_TO(BUS_TO)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .rx_data_i  (rx_data),
        .rx_rdy_i   (rx_rdy),
        .rx_error_i (rx_error),
        .rx_clr_o   (rx_clr),
        .tx_data_o  (tx_data),
        .tx_wr_o    (tx_wr),
        .tx_busy_i  (tx_busy),
        .bus_addr_o (bus_addr),
        .bus_dout_o (bus_dout),
        .bus_we_o   (bus_we),
        .bus_rd_o   (bus_rd),
        .bus_din_i  (bus_din),
        .bus_ok_i   (bus_ok)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model state ----------------
    typedef struct {
        bit we;
        int addr;
        int dout;
        int ack;
        int len;
    } bus_exp_t;

    bus_exp_t   bus_q[$];
    logic [7:0] rsp_q[$];
    logic [7:0] tx_log[$];
    logic [7:0] shadow [256];

    function automatic logic [7:0] seed_byte(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    // ---------------- RAM slave ----------------
    logic [7:0] ram [256];
    int req_cyc = 0;
    int cur_ack = 0;

    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) ram[i] <= seed_byte(i);
        end else if (bus_ok && bus_we) begin
            ram[bus_addr[7:0]] <= bus_dout;
        end
        if (bus_rd || bus_we) req_cyc <= req_cyc + 1;
        else                  req_cyc <= 0;
    end

    // The acknowledge lands in request cycle ack+2, so ack=0 answers the cycle after the request rises.
    assign bus_ok  = (bus_rd || bus_we) && (req_cyc == cur_ack + 1);
    assign bus_din = ram[bus_addr[7:0]];

    // ---------------- UART tx busy model ----------------
    int busy_cnt = 0;
    bit force_busy = 1'b0;

    always @(posedge clk) begin
        if (tx_wr)             busy_cnt <= $urandom_range(10, 1);
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    assign tx_busy = (busy_cnt != 0) || force_busy;

    // ---------------- monitor ----------------
    int req_len = 0;
    bit prev_tx_wr = 1'b0;
    bit prev_busy = 1'b0;
    int last_clr_cyc = 0;
    int last_tx_lat = 0;
    int tx_count = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            req_len    = 0;
            prev_tx_wr = 1'b0;
            bus_q.delete();
            rsp_q.delete();
        end else begin
            if (rx_clr) last_clr_cyc = cyc;
            if (bus_rd || bus_we) begin
                if (req_len == 0) begin
                    if (bus_q.size() == 0) begin
                        fail_now("bus_unexpected");
                    end else begin
                        chk("bus_we", int'(bus_we), int'(bus_q[0].we));
                        chk("bus_rd", int'(bus_rd), int'(!bus_q[0].we));
                        chk("bus_addr", int'(bus_addr), bus_q[0].addr);
                        if (bus_q[0].we) chk("bus_dout", int'(bus_dout), bus_q[0].dout);
                        cur_ack = bus_q[0].ack;
                    end
                end
                req_len++;
            end else if (req_len > 0) begin
                if (bus_q.size() > 0) begin
                    chk("bus_req_len", req_len, bus_q[0].len);
                    void'(bus_q.pop_front());
                end
                req_len = 0;
            end
            if (tx_wr) begin
                tx_count++;
                chk("tx_wr_single", int'(prev_tx_wr), 0);
                chk("tx_wr_while_busy", int'(prev_busy), 0);
                if (rsp_q.size() == 0) fail_now("tx_unexpected");
                else chk("tx_data", int'(tx_data), int'(rsp_q.pop_front()));
                tx_log.push_back(tx_data);
                last_tx_lat = cyc - last_clr_cyc;
            end
            prev_tx_wr = tx_wr;
            prev_busy  = tx_busy;
        end
    end

    // ---------------- host byte source ----------------
    task automatic send_byte(input logic [7:0] b, input bit err, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_error = err;
        rx_rdy   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rx_clr && n < 3000);
        if (!rx_clr) fail_now("rx_accept_timeout");
        rx_rdy   = 1'b0;
        rx_error = 1'b0;
    endtask

    // One frame: the expectations are queued first, then the bytes are sent.
    // err_at selects the byte carrying rx_error (-1: none). cut_at stops after that many bytes, then idles past TIMEOUT (-1: none).
    task automatic frame(input logic [7:0] op, input logic [15:0] a, input logic [7:0] d,
                         input int err_at, input int cut_at, input int ack,
                         input int gap_lo, input int gap_hi);
        logic [7:0] b [4];
        int nb, nsend, aa;
        bit timed;
        b[0] = op; b[1] = a[15:8]; b[2] = a[7:0]; b[3] = d;
        nb = (op == OP_RD) ? 3 : (op == OP_WR) ? 4 : 1;
        nsend = nb;
        if (err_at >= 0 && err_at < nb) begin
            nsend = err_at + 1;
            rsp_q.push_back(RPL_ERR);
        end else if (cut_at > 0 && cut_at < nb) begin
            nsend = cut_at;
        end else if (nb == 1) begin
            rsp_q.push_back(RPL_BAD);
        end else begin
            aa    = int'(a) % (1 << AW);
            timed = (ack + 2) > BUS_TO;
            bus_q.push_back('{we: (op == OP_WR), addr: aa, dout: int'(d), ack: ack,
                              len: timed ? BUS_TO : ack + 2});
            if (timed) begin
                rsp_q.push_back(RPL_ERR);
            end else if (op == OP_WR) begin
                rsp_q.push_back(RPL_OK);
                shadow[aa % 256] = d;
            end else begin
                rsp_q.push_back(shadow[aa % 256]);
            end
        end
        for (int i = 0; i < nsend; i++)
            send_byte(b[i], (i == err_at), $urandom_range(gap_hi, gap_lo));
        if (nsend < nb && !(err_at >= 0 && err_at < nb))
            repeat (TIMEOUT + 40) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0 || tx_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_now("drain_timeout");
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int txc;
        int opsel, ack, err_at, cut_at;
        logic [7:0] op, saved;
        logic [15:0] addr;

        rst_n = 1'b0; rx_data = 8'h00; rx_rdy = 1'b0; rx_error = 1'b0;
        for (int i = 0; i < 256; i++) shadow[i] = seed_byte(i);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_clr",   int'(rx_clr),   0);
        chk("rst_tx_wr",    int'(tx_wr),    0);
        chk("rst_bus_we",   int'(bus_we),   0);
        chk("rst_bus_rd",   int'(bus_rd),   0);
        chk("rst_tx_data",  int'(tx_data),  0);
        chk("rst_bus_addr", int'(bus_addr), 0);
        chk("rst_bus_dout", int'(bus_dout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write then read back through the model, with hand-computed literals alongside.
        frame(OP_WR, 16'h0010, 8'hA5, -1, -1, 0, 0, 3);
        frame(OP_RD, 16'h0010, 8'h00, -1, -1, 1, 0, 3);
        drain();
        chk("lit_wr_reply", int'(tx_log[0]), 8'h4B);
        chk("lit_rd_reply", int'(tx_log[1]), 8'hA5);
        chk("lit_ram_10",   int'(ram[8'h10]), 8'hA5);
        chk("lit_tx_count", tx_count, 2);

        // Unknown opcode, then a normal read.
        frame(8'h33, 16'h0000, 8'h00, -1, -1, 0, 0, 2);
        frame(OP_RD, 16'h0010, 8'h00, -1, -1, 0, 0, 2);
        drain();
        chk("lit_bad_reply", int'(tx_log[2]), 8'h3F);
        chk("lit_rd2_reply", int'(tx_log[3]), 8'hA5);

        // Zero-wait read latency from AL acceptance to tx_wr.
        frame(OP_RD, 16'h0010, 8'h00, -1, -1, 0, 0, 0);
        drain();
        chk("rd_latency", last_tx_lat, 3);

        // Inter-byte timeout: silent abandon, then a full frame.
        txc = tx_count;
        frame(OP_RD, 16'h0010, 8'h00, -1, 2, 0, 0, 2);
        drain();
        chk("timeout_no_reply", tx_count, txc);
        frame(OP_RD, 16'h0010, 8'h00, -1, -1, 0, 0, 2);
        drain();
        chk("after_timeout_reply", int'(tx_log[tx_log.size()-1]), 8'hA5);

        // Inter-byte gaps just under the timeout still complete the frame.
        frame(OP_WR, 16'h0123, 8'h5A, -1, -1, 1, TIMEOUT - 50, TIMEOUT - 40);
        drain();
        chk("long_gap_ram", int'(ram[8'h23]), 8'h5A);

        // Bus timeout, and an acknowledge in the final allowed cycle.
        frame(OP_RD, 16'h1234, 8'h00, -1, -1, BUS_TO + 5, 0, 2);
        drain();
        chk("bus_to_reply", int'(tx_log[tx_log.size()-1]), 8'h21);
        frame(OP_RD, 16'h1234, 8'h00, -1, -1, BUS_TO - 2, 0, 2);
        drain();
        chk("bus_last_ack_reply", int'(tx_log[tx_log.size()-1]), int'(seed_byte(8'h34)));

        // Corrupted AH in a write frame.
        saved = ram[8'h40];
        frame(OP_WR, 16'h0040, 8'h77, 1, -1, 0, 0, 2);
        drain();
        chk("rx_err_reply", int'(tx_log[tx_log.size()-1]), 8'h21);
        chk("rx_err_ram", int'(ram[8'h40]), int'(saved));

        // Transmitter held busy: no strobe until it is released.
        @(posedge clk); #1 force_busy = 1'b1;
        txc = tx_count;
        frame(OP_RD, 16'h0010, 8'h00, -1, -1, 0, 0, 1);
        repeat (40) @(negedge clk);
        chk("held_busy_no_tx", tx_count, txc);
        @(posedge clk); #1 force_busy = 1'b0;
        drain();
        chk("held_busy_one_tx", tx_count, txc + 1);

        // Randomized, back-to-back frames.
        for (int f = 0; f < 150; f++) begin
            opsel = $urandom_range(19, 0);
            op    = (opsel < 9) ? OP_RD : (opsel < 18) ? OP_WR : 8'($urandom_range(255, 0));
            if (op == OP_RD || op == OP_WR) begin
                if (opsel >= 18) op = 8'h00;
            end
            addr   = 16'($urandom);
            ack    = $urandom_range(BUS_TO + 3, 0);
            err_at = ($urandom_range(19, 0) == 0) ? $urandom_range(3, 0) : -1;
            cut_at = ($urandom_range(39, 0) == 0) ? $urandom_range(3, 1) : -1;
            frame(op, addr, 8'($urandom), err_at, cut_at, ack, 0, 5);
        end
        drain();
        chk("random_rsp_empty", rsp_q.size(), 0);

        // Reset while a write request is on the bus.
        saved = ram[8'h55];
        frame(OP_WR, 16'h0055, 8'h99, -1, -1, BUS_TO + 10, 0, 1);
        begin
            int n;
            n = 0;
            while (!bus_we && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("rst_test_bus_we_seen", int'(bus_we), 1);
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_bus_we",   int'(bus_we),   0);
        chk("async_rst_bus_rd",   int'(bus_rd),   0);
        chk("async_rst_bus_addr", int'(bus_addr), 0);
        chk("async_rst_bus_dout", int'(bus_dout), 0);
        chk("async_rst_tx_data",  int'(tx_data),  0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        frame(OP_RD, 16'h0055, 8'h00, -1, -1, 0, 0, 1);
        drain();
        chk("after_rst_reply", int'(tx_log[tx_log.size()-1]), int'(saved));
        chk("after_rst_ram", int'(ram[8'h55]), int'(saved));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
